// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, owner encoding and the all-ones byte-enable mask.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  // Wide enough for MEM_LAT-1 with MEM_LAT up to 4.
  localparam int CNT_W = 2;

  localparam int MAX_BE_W = 64;
  localparam logic [MAX_BE_W-1:0] BE_ALL = '1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core's fetch/load-store ports, the arbiter and the unified memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [BE_W-1:0]   ls_be;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_addr, ls_wdata, ls_be,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_addr, ls_wdata, ls_be,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and load/store requests.
// MEM_PORT_ARB_RR_EN: round-robin on contention; otherwise LS always beats IF.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   if_req,
  input  logic   ls_req,
  input  owner_t last,
  output logic   win_valid,
  output owner_t win_owner
);

`ifdef MEM_PORT_ARB_RR_EN
  always_comb begin
    win_valid = if_req | ls_req;
    win_owner = ls_req ? OWN_LS : OWN_IF;
    if (if_req && ls_req) begin
      win_owner = (last == OWN_IF) ? OWN_LS : OWN_IF;
    end
  end
`else
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    win_valid = if_req | ls_req;
    win_owner = ls_req ? OWN_LS : OWN_IF;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Unified-memory arbiter: one outstanding IF or LS access, registered memory strobes, fixed MEM_LAT read latency.
// Build option MEM_PORT_ARB_RR_EN selects round-robin instead of fixed LS-over-IF priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

  arb_state_t        state;
  logic [CNT_W-1:0]  cnt;
  owner_t            owner;
  owner_t            last;

  logic              win_valid;
  owner_t            win_owner;
  logic              take;
  logic              done_next;

  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [BE_W-1:0]   mem_be_q;

  logic              if_gnt_q;
  logic              ls_gnt_q;
  logic              if_rvalid_q;
  logic              ls_rvalid_q;
  logic [DATA_W-1:0] if_rd_q;
  logic [DATA_W-1:0] ls_rd_q;
  logic [DATA_W-1:0] ls_rdata_w;

  mem_arb_pick u_pick (
    .if_req    (bus.if_req),
    .ls_req    (bus.ls_req),
    .last      (last),
    .win_valid (win_valid),
    .win_owner (win_owner)
  );

  // Arbitration happens in IDLE and in the final WAIT cycle, so back-to-back grants are MEM_LAT+1 apart.
  assign take = win_valid && ((state == ST_IDLE) || (state == ST_WAIT && cnt == '0));

  // True when the next cycle is the final WAIT cycle, i.e. the cycle the memory data is valid.
  assign done_next = ((state == ST_ISSUE) && (MEM_LAT == 1)) ||
                     ((state == ST_WAIT) && (cnt == CNT_W'(1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      owner       <= OWN_IF;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rd_q     <= '0;
      ls_rd_q     <= '0;
    end else begin
      mem_en_q    <= 1'b0;
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_rvalid_q <= done_next && (owner == OWN_IF);
      ls_rvalid_q <= done_next && (owner == OWN_LS);

      if (if_rvalid_q) if_rd_q <= bus.mem_rdata;
      if (ls_rvalid_q) ls_rd_q <= ls_rdata_w;

      unique case (state)
        ST_IDLE: state <= ST_IDLE;
        ST_ISSUE: begin
          state <= ST_WAIT;
          cnt   <= LAT_M1;
        end
        ST_WAIT: begin
          if (cnt != '0) cnt   <= cnt - 1'b1;
          else           state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (take) begin
        state       <= ST_ISSUE;
        owner       <= win_owner;
        mem_en_q    <= 1'b1;
        if_gnt_q    <= (win_owner == OWN_IF);
        ls_gnt_q    <= (win_owner == OWN_LS);
        mem_we_q    <= (win_owner == OWN_LS) && bus.ls_we;
        mem_addr_q  <= (win_owner == OWN_LS) ? bus.ls_addr : bus.if_addr;
        mem_wdata_q <= (win_owner == OWN_LS) ? bus.ls_wdata : '0;
        mem_be_q    <= (win_owner == OWN_LS) ? bus.ls_be : BE_ALL[BE_W-1:0];
      end
    end
  end

`ifdef MEM_PORT_ARB_RR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last <= OWN_IF;
    end else if (take) begin
      last <= win_owner;
    end
  end
`else
  assign last = OWN_IF;
`endif

  // Read data is forwarded from memory in the rvalid cycle and held afterwards; stores report zero.
  assign ls_rdata_w    = mem_we_q ? '0 : bus.mem_rdata;
  assign bus.if_rdata  = if_rvalid_q ? bus.mem_rdata : if_rd_q;
  assign bus.ls_rdata  = ls_rvalid_q ? ls_rdata_w : ls_rd_q;

  assign bus.if_gnt    = if_gnt_q;
  assign bus.ls_gnt    = ls_gnt_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.ls_rvalid = ls_rvalid_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;

endmodule
